// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the stream_mux block.
package stream_mux_pkg;

    typedef enum logic [0:0] {
        SEL_EXT     = 1'b0,
        ROUND_ROBIN = 1'b1
    } mode_e;

    // Wrap-around increment of a channel index in the range [0, n).
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        if (idx + 32'd1 >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the channel that was actually accepted.
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         req,
    input  logic                    advance,
    input  logic [$clog2(N_CH)-1:0] adv_idx,
    output logic [$clog2(N_CH)-1:0] grant,
    output logic                    grant_valid
);

    localparam int IW = $clog2(N_CH);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] w_grant;
    logic          w_found;
    logic          w_hit;

    // Scan requesters starting at the pointer, wrapping modulo N_CH.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_hit   = 1'b0;
        w_idx   = r_ptr;
        for (int k = 0; k < N_CH; k++) begin
            w_hit   = !w_found && req[w_idx];
            w_grant = w_hit ? w_idx : w_grant;
            w_found = w_found | w_hit;
            w_idx   = IW'(next_idx(32'(w_idx), 32'(N_CH)));
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= IW'(next_idx(32'(adv_idx), 32'(N_CH)));
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign grant       = w_grant;
    assign grant_valid = |req;

endmodule

// File: rtl/stream_mux.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Optional packet locking is enabled by defining STREAM_MUX_PKT_LOCK_EN.
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int WIDTH = 8,
    parameter int MODE  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(N_CH)-1:0] sel,
    input  logic [N_CH-1:0]         in_valid,
    output logic [N_CH-1:0]         in_ready,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic [N_CH-1:0]         in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_last,
    output logic [$clog2(N_CH)-1:0] out_ch
);

    localparam int IW = $clog2(N_CH);

    logic             w_load_en;
    logic             w_accept;
    logic             w_base_ok;
    logic             w_grant_ok;
    logic [IW-1:0]    w_base_g;
    logic [IW-1:0]    w_g;
    logic [WIDTH-1:0] w_data;
    logic             w_last;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic [IW-1:0]    r_out_ch;

    generate
        if (MODE == int'(ROUND_ROBIN)) begin : g_rr
            logic w_unused_sel;
            assign w_unused_sel = ^sel;
            rr_arbiter #(.N_CH(N_CH)) u_arb (
                .clk         (clk),
                .rst         (rst),
                .req         (in_valid),
                .advance     (w_accept),
                .adv_idx     (w_g),
                .grant       (w_base_g),
                .grant_valid (w_base_ok)
            );
        end else begin : g_ext
            assign w_base_g  = sel;
            assign w_base_ok = (32'(sel) < 32'(N_CH));
        end
    endgenerate

`ifdef STREAM_MUX_PKT_LOCK_EN
    logic          r_lock;
    logic [IW-1:0] r_locked_ch;

    // A beat without last pins the grant to its channel until the last beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock      <= 1'b0;
            r_locked_ch <= '0;
        end else if (w_accept) begin
            r_lock      <= !w_last;
            r_locked_ch <= w_g;
        end else begin
            r_lock      <= r_lock;
            r_locked_ch <= r_locked_ch;
        end
    end

    assign w_g        = r_lock ? r_locked_ch : w_base_g;
    assign w_grant_ok = r_lock | w_base_ok;
`else
    assign w_g        = w_base_g;
    assign w_grant_ok = w_base_ok;
`endif

    assign w_load_en = !r_out_valid || out_ready;

    // One-hot ready and the matching data/last selection.
    always_comb begin
        in_ready = '0;
        w_data   = '0;
        w_last   = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            in_ready[c] = !rst && w_load_en && w_grant_ok && (w_g == IW'(c));
            w_data      = w_data | (in_data[c*WIDTH +: WIDTH] & {WIDTH{in_ready[c]}});
            w_last      = w_last | (in_last[c] & in_ready[c]);
        end
    end

    assign w_accept = |(in_valid & in_ready);

    // Output stage: load on accept, empty when draining with nothing new.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_ch    <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_data;
            r_out_last  <= w_last;
            r_out_ch    <= w_g;
        end else if (w_load_en) begin
            r_out_valid <= 1'b0;
            r_out_data  <= r_out_data;
            r_out_last  <= r_out_last;
            r_out_ch    <= r_out_ch;
        end else begin
            r_out_valid <= r_out_valid;
            r_out_data  <= r_out_data;
            r_out_last  <= r_out_last;
            r_out_ch    <= r_out_ch;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_ch    = r_out_ch;

endmodule
